bsg_lru_pseudo_tree_tracker: RTL and testbench

- Stateful pseudo-LRU tracker for a set-associative structure, holding one (ways_p-1)-bit tree-PLRU vector per set.
- Update side is the decode direction: a way id is expanded into node data/mask and written into the set's tree.
- Victim side encodes the stored tree into a way id.
- Sits beside a cache tag array: hits issue touches, misses issue allocations and receive a registered victim way.

---
 rtl/bsg_lru_pseudo_tree_tracker.sv | 132 +++++++++++++
 tb/tb_bsg_lru_pseudo_tree_tracker.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_lru_pseudo_tree_tracker.sv
// Tree pseudo-LRU tracker: one (ways_p-1)-bit PLRU tree per set.
// Touches mark a way MRU; allocs return a registered victim and mark it MRU.
// State table:
//   INIT  | zeroing one set per cycle after reset, inputs ignored
//   READY | touches and allocs accepted
module bsg_lru_pseudo_tree_tracker #(
  parameter int ways_p = 8,
  parameter int sets_p = 4,
  localparam int lg_ways_lp = $clog2(ways_p),
  localparam int lg_sets_lp = (sets_p > 1) ? $clog2(sets_p) : 1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  output logic                  ready_o,
  input  logic                  touch_v_i,
  input  logic [lg_sets_lp-1:0] touch_set_i,
  input  logic [lg_ways_lp-1:0] touch_way_i,
  input  logic                  alloc_v_i,
  input  logic [lg_sets_lp-1:0] alloc_set_i,
  output logic                  alloc_v_o,
  output logic [lg_ways_lp-1:0] alloc_way_o
);

  typedef enum logic {INIT, READY} state_e;

  localparam logic [lg_sets_lp-1:0] last_set_lp = lg_sets_lp'(sets_p - 1);

  state_e                  state_r;
  logic [lg_sets_lp-1:0]   sweep_cnt_r;
  logic                    ready_r;
  logic                    alloc_v_r;
  logic [lg_ways_lp-1:0]   alloc_way_r;
  logic [ways_p-2:0]       tree_r [sets_p];

  logic [lg_sets_lp-1:0]   touch_idx, alloc_idx;
  logic [lg_ways_lp-1:0]   victim;
  logic [ways_p-2:0]       touch_tree, alloc_base, alloc_tree;
  int                      touch_set_n, alloc_set_n;

  // Walk the tree from the root; each visited node bit becomes one way bit.
  function automatic logic [lg_ways_lp-1:0] encode(input logic [ways_p-2:0] t);
    logic [lg_ways_lp-1:0] node;
    logic [lg_ways_lp-1:0] way;
    logic                  b;
    node = '0;
    way  = '0;
    for (int k = 0; k < lg_ways_lp; k++) begin
      b = t[node];
      way[lg_ways_lp-1-k] = b;
      node = (node << 1) + lg_ways_lp'(1) + lg_ways_lp'(b);
    end
    return way;
  endfunction

  // Point every node on way w's path away from w; other nodes keep their value.
  function automatic logic [ways_p-2:0] mark_mru(input logic [ways_p-2:0] t,
                                                 input logic [lg_ways_lp-1:0] w);
    logic [lg_ways_lp-1:0] node;
    logic [ways_p-2:0]     r;
    r = t;
    for (int k = 0; k < lg_ways_lp; k++) begin
      node = ((lg_ways_lp'(1) << k) - lg_ways_lp'(1)) + (w >> (lg_ways_lp - k));
      r[node] = ~w[lg_ways_lp-1-k];
    end
    return r;
  endfunction

  // Victim from the pre-update tree; touch applied first, alloc layered on top.
  always_comb begin
    touch_idx   = (sets_p == 1) ? '0 : touch_set_i;
    alloc_idx   = (sets_p == 1) ? '0 : alloc_set_i;
    touch_set_n = 32'(touch_set_i);
    alloc_set_n = 32'(alloc_set_i);
    victim      = encode(tree_r[alloc_idx]);
    touch_tree  = mark_mru(tree_r[touch_idx], touch_way_i);
    alloc_base  = (touch_v_i && (touch_idx == alloc_idx)) ? touch_tree : tree_r[alloc_idx];
    alloc_tree  = mark_mru(alloc_base, victim);
  end

  // Control FSM with registered ready and victim outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r     <= INIT;
      sweep_cnt_r <= '0;
      ready_r     <= 1'b0;
      alloc_v_r   <= 1'b0;
      alloc_way_r <= '0;
    end else begin
      case (state_r)
        INIT: begin
          alloc_v_r <= 1'b0;
          if (sweep_cnt_r == last_set_lp) begin
            state_r     <= READY;
            ready_r     <= 1'b1;
            sweep_cnt_r <= '0;
          end else begin
            sweep_cnt_r <= sweep_cnt_r + lg_sets_lp'(1);
          end
        end
        READY: begin
          alloc_v_r <= alloc_v_i;
          if (alloc_v_i) alloc_way_r <= victim;
        end
        default: state_r <= INIT;
      endcase
    end
  end

  // Tree storage: cleared by the sweep, updated by accepted touches/allocs.
  // The alloc write comes last so it wins when both target the same set.
  always_ff @(posedge clk_i) begin
    if (state_r == INIT) begin
      tree_r[sweep_cnt_r] <= '0;
    end else if (!reset_i) begin
      if (touch_v_i) tree_r[touch_idx] <= touch_tree;
      if (alloc_v_i) tree_r[alloc_idx] <= alloc_tree;
    end
  end

  // Out-of-range set indices are illegal while inputs are being accepted.
  always_ff @(posedge clk_i) begin
    if (!reset_i && state_r == READY && sets_p > 1) begin
      if (touch_v_i) assert (touch_set_n < sets_p);
      if (alloc_v_i) assert (alloc_set_n < sets_p);
    end
  end

  assign ready_o     = ready_r;
  assign alloc_v_o   = alloc_v_r;
  assign alloc_way_o = alloc_way_r;

endmodule

// File: tb/tb_bsg_lru_pseudo_tree_tracker.sv
// Bench for bsg_lru_pseudo_tree_tracker: directed scenarios plus random traffic
// checked every cycle against a node-array reference model.
module tb_bsg_lru_pseudo_tree_tracker;

  localparam int WAYS = 8;
  localparam int SETS = 4;
  localparam int LGW  = 3;
  localparam int LGS  = 2;

  logic           clk;
  logic           rst;
  logic           ready;
  logic           touch_v;
  logic [LGS-1:0] touch_set;
  logic [LGW-1:0] touch_way;
  logic           alloc_v;
  logic [LGS-1:0] alloc_set;
  logic           alloc_v_out;
  logic [LGW-1:0] alloc_way;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit m_tree [SETS][WAYS-1];
  int init_left;
  int exp_v;
  int exp_way;

  bsg_lru_pseudo_tree_tracker #(.ways_p(WAYS), .sets_p(SETS)) dut (
    .clk_i      (clk),
    .reset_i    (rst),
    .ready_o    (ready),
    .touch_v_i  (touch_v),
    .touch_set_i(touch_set),
    .touch_way_i(touch_way),
    .alloc_v_i  (alloc_v),
    .alloc_set_i(alloc_set),
    .alloc_v_o  (alloc_v_out),
    .alloc_way_o(alloc_way)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Root-to-leaf walk: at each node go left on 0, right on 1; the turns form the way id.
  function automatic int m_encode(input int s);
    int node = 0;
    int way = 0;
    for (int k = 0; k < LGW; k++) begin
      way  = way * 2 + int'(m_tree[s][node]);
      node = 2 * node + 1 + int'(m_tree[s][node]);
    end
    return way;
  endfunction

  // Level-k node on w's path is (2^k - 1) + top k bits of w; point it away from w.
  task automatic m_touch(input int s, input int w);
    int node;
    for (int k = 0; k < LGW; k++) begin
      node = (2 ** k) - 1 + (w / (2 ** (LGW - k)));
      m_tree[s][node] = ((w / (2 ** (LGW - 1 - k))) % 2) == 0;
    end
  endtask

  task automatic step();
    int vic;
    @(posedge clk);
    if (rst) begin
      init_left = SETS;
      for (int s = 0; s < SETS; s++)
        for (int n = 0; n < WAYS - 1; n++) m_tree[s][n] = 1'b0;
      exp_v   = 0;
      exp_way = 0;
    end else if (init_left > 0) begin
      init_left--;
      exp_v = 0;
    end else begin
      vic = m_encode(int'(alloc_set));
      if (touch_v) m_touch(int'(touch_set), int'(touch_way));
      if (alloc_v) m_touch(int'(alloc_set), vic);
      exp_v = alloc_v ? 1 : 0;
      if (alloc_v) exp_way = vic;
    end
    #1;
    chk("ready", 32'(ready), (init_left == 0) ? 32'd1 : 32'd0);
    chk("alloc_v", 32'(alloc_v_out), 32'(exp_v));
    chk("alloc_way", 32'(alloc_way), 32'(exp_way));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    touch_v = 1'b0;
    alloc_v = 1'b0;
    step();
    rst = 1'b0;
    repeat (SETS) step();
  endtask

  int seq [9] = '{0, 4, 2, 6, 1, 5, 3, 7, 0};

  initial begin
    rst = 1'b1;
    touch_v = 1'b0;
    touch_set = '0;
    touch_way = '0;
    alloc_v = 1'b1;
    alloc_set = 2'd2;
    init_left = SETS;
    exp_v = 0;
    exp_way = 0;

    // reset with alloc held, sweep, then 9 allocs to set 2
    step();
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_alloc_v", 32'(alloc_v_out), 32'd0);
    chk("rst_alloc_way", 32'(alloc_way), 32'd0);
    step();
    rst = 1'b0;
    repeat (3) begin
      step();
      chk("sweep_ready", 32'(ready), 32'd0);
      chk("sweep_alloc_v", 32'(alloc_v_out), 32'd0);
    end
    step();
    chk("sweep_done_ready", 32'(ready), 32'd1);
    chk("sweep_done_alloc_v", 32'(alloc_v_out), 32'd0);
    for (int i = 0; i < 9; i++) begin
      step();
      chk("seq_v", 32'(alloc_v_out), 32'd1);
      chk("seq_way", 32'(alloc_way), 32'(seq[i]));
    end
    alloc_v = 1'b0;
    step();
    chk("hold_v", 32'(alloc_v_out), 32'd0);
    chk("hold_way", 32'(alloc_way), 32'd0);

    // touch way 5 then alloc same set
    do_reset();
    touch_v = 1'b1; touch_set = 2'd1; touch_way = 3'd5;
    step();
    touch_v = 1'b0; alloc_v = 1'b1; alloc_set = 2'd1;
    step();
    chk("touch5_victim", 32'(alloc_way), 32'd0);
    alloc_v = 1'b0;

    // touch way 0 then alloc same set; other set unaffected
    do_reset();
    touch_v = 1'b1; touch_set = 2'd1; touch_way = 3'd0;
    step();
    touch_v = 1'b0; alloc_v = 1'b1; alloc_set = 2'd1;
    step();
    chk("touch0_victim", 32'(alloc_way), 32'd4);
    alloc_set = 2'd0;
    step();
    chk("other_set_victim", 32'(alloc_way), 32'd0);
    alloc_v = 1'b0;

    // same cycle, same set
    do_reset();
    touch_v = 1'b1; touch_set = 2'd3; touch_way = 3'd0;
    alloc_v = 1'b1; alloc_set = 2'd3;
    step();
    chk("same_set_victim", 32'(alloc_way), 32'd0);
    touch_v = 1'b0;
    step();
    chk("same_set_next", 32'(alloc_way), 32'd4);
    alloc_v = 1'b0;

    // same cycle, different sets
    do_reset();
    touch_v = 1'b1; touch_set = 2'd0; touch_way = 3'd3;
    alloc_v = 1'b1; alloc_set = 2'd1;
    step();
    chk("diff_set_victim", 32'(alloc_way), 32'd0);
    touch_v = 1'b0; alloc_set = 2'd0;
    step();
    chk("diff_set0_next", 32'(alloc_way), 32'd4);
    alloc_set = 2'd1;
    step();
    chk("diff_set1_next", 32'(alloc_way), 32'd4);
    alloc_v = 1'b0;

    // reset in the middle of an alloc stream
    do_reset();
    alloc_v = 1'b1; alloc_set = 2'd2;
    repeat (3) step();
    rst = 1'b1;
    step();
    chk("midrst_alloc_v", 32'(alloc_v_out), 32'd0);
    rst = 1'b0; alloc_set = 2'd0;
    repeat (3) begin
      step();
      chk("midrst_sweep_ready", 32'(ready), 32'd0);
    end
    step();
    chk("midrst_ready", 32'(ready), 32'd1);
    for (int s = 0; s < SETS; s++) begin
      alloc_set = 2'(s);
      step();
      chk("midrst_victim", 32'(alloc_way), 32'd0);
    end
    alloc_v = 1'b0;
    step();

    // random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 79) == 0);
      touch_v   = 1'($urandom_range(0, 1));
      touch_set = 2'($urandom_range(0, SETS - 1));
      touch_way = 3'($urandom_range(0, WAYS - 1));
      alloc_v   = 1'($urandom_range(0, 1));
      alloc_set = ($urandom_range(0, 3) == 0) ? touch_set : 2'($urandom_range(0, SETS - 1));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
